// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program load sequencer:
//   - default geometry of the program memory (word width, address width, depth)
//   - sequencer state encoding (CHECK is always present in the encoding, even
//     when the checksum feature is compiled out, so the encoding never shifts)
// -----------------------------------------------------------------------------
package program_loader_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int DEPTH_DEF      = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_RUN   = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

endpackage

// File: rtl/load_checksum_acc.sv
// -----------------------------------------------------------------------------
// load_checksum_acc
// Running modulo-2**DATA_WIDTH sum of the words accepted in a load session,
// with a combinational compare against a host-supplied check word.
// Only instantiated when PROGRAM_LOAD_CHECKSUM_EN is defined.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   clear       in   zero the accumulator (has priority over add)
//   add         in   add data into the accumulator this cycle
//   data        in   word to accumulate
//   check_data  in   word to compare against the current sum
//   match       out  1 when check_data equals the current sum
// -----------------------------------------------------------------------------
module load_checksum_acc
   import program_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  add,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [DATA_WIDTH-1:0] check_data,
   output logic                  match
);

   logic [DATA_WIDTH-1:0] sum;

   // Overflow wraps naturally at DATA_WIDTH bits, which is the intended modulus.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (add) begin
         sum <= sum + data;
      end
   end

   assign match = (sum == check_data);

endmodule

// File: rtl/program_load_sequencer.sv
// -----------------------------------------------------------------------------
// program_load_sequencer
// Loads a program from a host valid/ready stream into program memory at
// consecutive addresses starting at 0, then hands the shared memory port to
// the CPU and holds the CPU run enable.
//
// Optional feature (macro PROGRAM_LOAD_CHECKSUM_EN): after the last data word
// the host sends one extra check word equal to the modulo-2**DATA_WIDTH sum of
// the data words; it is compared but never written. Match -> DONE, else ERROR.
//
// Ports:
//   clock, reset          system clock (rising edge), async active-low reset
//   host_start            begin a load session (sampled only in IDLE)
//   host_length           word count for the session, legal 1..DEPTH
//   host_valid/host_data  host word stream
//   host_ready            sequencer accepts host_data (LOAD/CHECK)
//   host_run              release the CPU (sampled in DONE)
//   host_abort            return to IDLE from any state, highest priority
//   cpu_fetch_addr        CPU fetch address, routed to memory in RUN
//   mem_addr/mem_wdata/mem_we  shared program memory port
//   cpu_run               CPU execution enable
//   load_done             load complete, awaiting host_run (level)
//   load_error            session rejected or failed (level until abort)
//   words_loaded          words accepted in the current session
// -----------------------------------------------------------------------------
module program_load_sequencer
   import program_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  host_start,
   input  logic [ADDR_WIDTH:0]   host_length,
   input  logic                  host_valid,
   input  logic [DATA_WIDTH-1:0] host_data,
   output logic                  host_ready,
   input  logic                  host_run,
   input  logic                  host_abort,
   input  logic [ADDR_WIDTH-1:0] cpu_fetch_addr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  cpu_run,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);

   state_t              state, state_next;
   logic [ADDR_WIDTH:0] length_q, length_next;
   logic [ADDR_WIDTH:0] count_q, count_next;
   logic [ADDR_WIDTH:0] count_inc;
   logic                accept;
   logic                length_ok;

   assign host_ready = (state == ST_LOAD) || (state == ST_CHECK);
   assign accept     = host_valid && host_ready;
   assign count_inc  = count_q + 1'b1;
   assign length_ok  = (host_length != '0) && (host_length <= DEPTH_C);

`ifdef PROGRAM_LOAD_CHECKSUM_EN
   logic sum_match;

   load_checksum_acc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_checksum (
      .clock      (clock),
      .reset      (reset),
      .clear      (state == ST_IDLE),
      .add        ((state == ST_LOAD) && accept),
      .data       (host_data),
      .check_data (host_data),
      .match      (sum_match)
   );
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         length_q <= '0;
         count_q  <= '0;
      end else begin
         state    <= state_next;
         length_q <= length_next;
         count_q  <= count_next;
      end
   end

   // NOTE: every variable gets a default at the top of the always_comb so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_next  = state;
      length_next = length_q;
      count_next  = count_q;

      if (host_abort) begin
         state_next = ST_IDLE;
         count_next = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (host_start) begin
                  count_next = '0;
                  if (length_ok) begin
                     length_next = host_length;
                     state_next  = ST_LOAD;
                  end else begin
                     state_next  = ST_ERROR;
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  count_next = count_inc;
                  if (count_inc == length_q) begin
`ifdef PROGRAM_LOAD_CHECKSUM_EN
                     state_next = ST_CHECK;
`else
                     state_next = ST_DONE;
`endif
                  end
               end
            end
            ST_CHECK: begin
`ifdef PROGRAM_LOAD_CHECKSUM_EN
               if (accept) begin
                  state_next = sum_match ? ST_DONE : ST_ERROR;
               end
`else
               // Unreachable without the checksum feature; recover to IDLE.
               state_next = ST_IDLE;
`endif
            end
            ST_DONE: begin
               if (host_run) begin
                  state_next = ST_RUN;
               end
            end
            ST_RUN:   state_next = ST_RUN;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // Memory port ownership: loader in LOAD/CHECK, CPU in RUN, parked at 0 else.
   // The check word is never written, so mem_we only asserts in LOAD.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      unique case (state)
         ST_LOAD: begin
            mem_addr  = count_q[ADDR_WIDTH-1:0];
            mem_wdata = host_data;
            mem_we    = accept;
         end
         ST_CHECK: mem_addr = count_q[ADDR_WIDTH-1:0];
         ST_RUN:   mem_addr = cpu_fetch_addr;
         default: begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = 1'b0;
         end
      endcase
   end

   assign cpu_run      = (state == ST_RUN);
   assign load_done    = (state == ST_DONE);
   assign load_error   = (state == ST_ERROR);
   assign words_loaded = count_q;

endmodule

// File: tb/tb_program_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_load_sequencer
// Scoreboarded bench: the stimulus side pushes every memory write it expects
// (address = position of the word in the session, data = the word) into a
// queue; a monitor on the falling edge pops one entry per observed write and
// compares. Status outputs are checked against values derived from the
// session description (length, words sent, checksum of the words).
// Build with +define+PROGRAM_LOAD_CHECKSUM_EN to exercise the check word.
// -----------------------------------------------------------------------------
module tb_program_load_sequencer;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int DEPTH = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          host_start;
   logic [AW:0]   host_length;
   logic          host_valid;
   logic [DW-1:0] host_data;
   logic          host_ready;
   logic          host_run;
   logic          host_abort;
   logic [AW-1:0] cpu_fetch_addr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          cpu_run;
   logic          load_done;
   logic          load_error;
   logic [AW:0]   words_loaded;

   int checks = 0;
   int errors = 0;
   wr_t exp_q[$];

   program_load_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .host_start     (host_start),
      .host_length    (host_length),
      .host_valid     (host_valid),
      .host_data      (host_data),
      .host_ready     (host_ready),
      .host_run       (host_run),
      .host_abort     (host_abort),
      .cpu_fetch_addr (cpu_fetch_addr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_we         (mem_we),
      .cpu_run        (cpu_run),
      .load_done      (load_done),
      .load_error     (load_error),
      .words_loaded   (words_loaded)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor: every observed write must match the oldest expected one.
   always @(negedge clock) begin
      if (reset && mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=0x%0h, expected none at %0t",
                     mem_addr, mem_wdata, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(mem_addr), 32'(e.addr));
            check("write_data", 32'(mem_wdata), 32'(e.data));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_session(input int len);
      host_start  = 1'b1;
      host_length = (AW+1)'(len);
      tick();
      host_start  = 1'b0;
   endtask

   // One cycle of host stream; a valid cycle in LOAD is an expected write.
   task automatic drive(input logic v, input logic [DW-1:0] d, input int addr, input bit expect_wr);
      host_valid = v;
      host_data  = d;
      if (v && expect_wr) exp_q.push_back('{addr: AW'(addr), data: d});
      tick();
      host_valid = 1'b0;
   endtask

   // Send a word after 0..max_gap idle cycles of junk data.
   task automatic send_word(input logic [DW-1:0] d, input int addr, input int max_gap);
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) drive(1'b0, DW'($urandom), 0, 1'b0);
      drive(1'b1, d, addr, 1'b1);
   endtask

   // Complete a session of len words; ends in DONE. words: optional fixed data.
   logic [DW-1:0] fixed_words[$];
   task automatic load_session(input int len, input int max_gap);
      logic [DW-1:0] sum;
      logic [DW-1:0] d;
      sum = '0;
      start_session(len);
      for (int i = 0; i < len; i++) begin
         d = (i < fixed_words.size()) ? fixed_words[i] : DW'($urandom);
         sum += d;
         send_word(d, i, max_gap);
      end
`ifdef PROGRAM_LOAD_CHECKSUM_EN
      check("check_state_ready", 32'(host_ready), 32'(1));
      drive(1'b1, sum, 0, 1'b0);
`endif
      check("done_level", 32'(load_done), 32'(1));
      check("done_words", 32'(words_loaded), 32'(len));
      check("done_ready", 32'(host_ready), 32'(0));
      check("done_addr", 32'(mem_addr), 32'(0));
      fixed_words.delete();
   endtask

   task automatic release_cpu(input int len);
      logic [AW-1:0] fa;
      host_start  = 1'b1;       // ignored in DONE
      host_length = 6'd3;
      tick();
      host_start  = 1'b0;
      check("done_ignores_start", 32'(load_done), 32'(1));
      host_run = 1'b1;
      tick();
      host_run = 1'b0;
      fa = AW'($urandom);
      cpu_fetch_addr = fa;
      #1;
      check("run_cpu_run", 32'(cpu_run), 32'(1));
      check("run_mem_addr", 32'(mem_addr), 32'(fa));
      check("run_load_done", 32'(load_done), 32'(0));
      check("run_words", 32'(words_loaded), 32'(len));
   endtask

   task automatic abort_now();
      host_abort = 1'b1;
      tick();
      host_abort = 1'b0;
      check("abort_words", 32'(words_loaded), 32'(0));
      check("abort_cpu_run", 32'(cpu_run), 32'(0));
      check("abort_error", 32'(load_error), 32'(0));
      check("abort_ready", 32'(host_ready), 32'(0));
   endtask

   initial begin
      int pat[7];
      int idx;
      logic [DW-1:0] d;
      reset = 1'b0;
      host_start = 0; host_length = '0; host_valid = 0; host_data = '0;
      host_run = 0; host_abort = 0; cpu_fetch_addr = '0;
      #12;
      check("reset_ready", 32'(host_ready), 32'(0));
      check("reset_we", 32'(mem_we), 32'(0));
      check("reset_cpu_run", 32'(cpu_run), 32'(0));
      check("reset_done", 32'(load_done), 32'(0));
      check("reset_error", 32'(load_error), 32'(0));
      check("reset_words", 32'(words_loaded), 32'(0));
      check("reset_addr", 32'(mem_addr), 32'(0));
      check("reset_wdata", 32'(mem_wdata), 32'(0));
      reset = 1'b1;
      tick();

      // Basic load of three known words with valid held high.
      fixed_words = '{16'h1234, 16'hABCD, 16'h0F0F};
      load_session(3, 0);
      cpu_fetch_addr = 5;
      release_cpu(3);
      cpu_fetch_addr = 5;
      #1 check("run_fetch5", 32'(mem_addr), 32'(5));
      host_start = 1'b1; host_run = 1'b1;  // both ignored in RUN
      tick();
      host_start = 1'b0; host_run = 1'b0;
      check("run_ignores_start", 32'(cpu_run), 32'(1));
      abort_now();

      // Host gaps: valid pattern 1,0,0,1,1,0,1 delivers 4 words.
      pat = '{1, 0, 0, 1, 1, 0, 1};
      start_session(4);
      idx = 0;
      for (int i = 0; i < 7; i++) begin
         d = DW'($urandom);
         drive(pat[i] != 0, d, idx, 1'b1);
         if (pat[i] != 0) idx++;
      end
`ifdef PROGRAM_LOAD_CHECKSUM_EN
      // Sum is not tracked here; a wrong check word must land in ERROR.
      drive(1'b1, 16'h0, 0, 1'b0);
      check("gaps_words", 32'(words_loaded), 32'(4));
      abort_now();
`else
      check("gaps_words", 32'(words_loaded), 32'(4));
      check("gaps_done", 32'(load_done), 32'(1));
      abort_now();
`endif

      // Bad lengths 0 and 33 (and a random out-of-range one).
      for (int k = 0; k < 3; k++) begin
         int bl;
         bl = (k == 0) ? 0 : (k == 1) ? 33 : int'($urandom_range(33, 63));
         start_session(bl);
         check("badlen_error", 32'(load_error), 32'(1));
         check("badlen_ready", 32'(host_ready), 32'(0));
         start_session(2);   // ignored in ERROR
         check("error_holds", 32'(load_error), 32'(1));
         check("error_cpu_run", 32'(cpu_run), 32'(0));
         abort_now();
      end

      // Abort after 2 of 5 words, then a 1-word session writes address 0.
      start_session(5);
      send_word(DW'($urandom), 0, 1);
      send_word(DW'($urandom), 1, 1);
      check("midload_words", 32'(words_loaded), 32'(2));
      abort_now();
      load_session(1, 0);
      abort_now();

      // Full depth: 32 words, last at address 31, no wrap.
      load_session(DEPTH, 0);
      release_cpu(DEPTH);
      abort_now();

`ifdef PROGRAM_LOAD_CHECKSUM_EN
      // Check word mismatch: 1+2 with check 4 -> ERROR, no write on check word.
      start_session(2);
      send_word(16'h0001, 0, 0);
      send_word(16'h0002, 1, 0);
      drive(1'b1, 16'h0004, 0, 1'b0);
      check("csum_mismatch_error", 32'(load_error), 32'(1));
      check("csum_mismatch_done", 32'(load_done), 32'(0));
      abort_now();
      fixed_words = '{16'h0001, 16'h0002};
      load_session(2, 0);
      abort_now();
`endif

      // Randomized sessions with random gaps and random lengths.
      for (int s = 0; s < 6; s++) begin
         int len;
         len = int'($urandom_range(1, DEPTH));
         load_session(len, 3);
         if ($urandom_range(0, 1) == 1) release_cpu(len);
         abort_now();
      end

      // Asynchronous reset mid-RUN and mid-LOAD.
      load_session(2, 0);
      release_cpu(2);
      #2 reset = 1'b0;
      #1;
      check("async_rst_cpu_run", 32'(cpu_run), 32'(0));
      check("async_rst_addr", 32'(mem_addr), 32'(0));
      #3 reset = 1'b1;
      tick();
      start_session(4);
      send_word(DW'($urandom), 0, 0);
      #2 reset = 1'b0;
      #1;
      check("rst_midload_ready", 32'(host_ready), 32'(0));
      check("rst_midload_words", 32'(words_loaded), 32'(0));
      #3 reset = 1'b1;
      tick();
      load_session(1, 0);
      abort_now();

      tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/program_load_sequencer.md
Name: program_load_sequencer

Overview:
- Sequences program loading and CPU start-up for unified_system.
- Accepts instruction words from a host over a valid/ready stream and writes them into program memory at consecutive addresses.
- Then hands the shared memory port to the CPU and holds the CPU run enable.
- Replaces ad-hoc prog_write_enable/start_execution driving with a checked handshake.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 5, program memory address width.
- DEPTH, 32, program memory words; must equal 2**ADDR_WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- host_start  input  1  begin load session; sampled only in IDLE.
- host_length  input  ADDR_WIDTH+1  word count for the session; legal 1..DEPTH.
- host_valid  input  1  host_data valid.
- host_data  input  DATA_WIDTH  instruction word.
- host_ready  output  1  sequencer accepts host_data.
- host_run  input  1  release CPU; sampled in DONE.
- host_abort  input  1  return to IDLE from any state.
- cpu_fetch_addr  input  ADDR_WIDTH  CPU fetch address.
- mem_addr  output  ADDR_WIDTH  shared program memory address.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_we  output  1  write enable.
- cpu_run  output  1  CPU execution enable.
- load_done  output  1  load complete, awaiting host_run.
- load_error  output  1  session rejected or failed.
- words_loaded  output  ADDR_WIDTH+1  words accepted in current session.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - host_ready, mem_we, cpu_run, load_done, load_error = 0.
  - words_loaded=0; mem_addr=0; mem_wdata=0.
- States: IDLE, LOAD, CHECK (macro only), DONE, RUN, ERROR. State and counters are registered. Port outputs are combinational from state and registers.
- IDLE:
  - host_start with host_length in 1..DEPTH: latch length, words_loaded=0, go to LOAD next cycle.
  - host_start with host_length==0 or >DEPTH: go to ERROR.
- LOAD:
  - host_ready=1.
  - Each cycle with host_valid&host_ready: mem_we=1, mem_addr=words_loaded[ADDR_WIDTH-1:0], mem_wdata=host_data in that same cycle (zero latency); words_loaded increments at the clock edge.
  - host_valid low: mem_we=0, no increment. Gaps of any length are allowed.
  - The acceptance that makes words_loaded==length: go to DONE (or CHECK if macro); host_ready drops the next cycle.
  - length==DEPTH: last write goes to address DEPTH-1; words_loaded reaches DEPTH with no address wrap.
- DONE:
  - load_done=1 (level); mem_we=0; host_ready=0.
  - host_run: go to RUN.
  - host_start ignored.
- RUN:
  - cpu_run=1; mem_addr=cpu_fetch_addr; mem_we=0.
  - load_done=0; words_loaded holds its value.
  - host_start and host_run ignored.
- ERROR:
  - load_error=1 (level) until host_abort.
  - host_ready=0; cpu_run=0.
- host_abort:
  - Highest priority in every state: next state IDLE, words_loaded=0, load_error cleared.
  - A same-cycle handshake in LOAD still writes memory (mem_we follows host_valid&host_ready), but the session is discarded.
- Memory port ownership: LOAD and CHECK belong to the loader; RUN belongs to the CPU; IDLE, DONE and ERROR drive mem_addr=0 with no write.
- Reset asserted mid-LOAD or mid-RUN: immediate IDLE; cpu_run drops asynchronously.

Optional Feature:
- Macro: PROGRAM_LOAD_CHECKSUM_EN.
- With the macro:
  - A 16-bit accumulator sums (mod 2**DATA_WIDTH) every accepted word.
  - After the last data word the state is CHECK with host_ready=1. The next accepted word is compared to the sum and is not written (mem_we=0).
  - Match: DONE. Mismatch: ERROR.
- Without the macro: no CHECK state; LOAD goes straight to DONE.

Decomposition:
- Package program_loader_pkg:
  - state enum with the encoding above (CHECK is always defined in the enum).
  - default DATA_WIDTH, ADDR_WIDTH and DEPTH constants.
- One sub-module, load_checksum_acc: accumulator with clear/add/compare. Instantiated only under PROGRAM_LOAD_CHECKSUM_EN.
- The memory-port mux stays inline.

Test Plan:
- Basic load: host_start, length=3; words 0x1234, 0xABCD, 0x0F0F with valid held high -> mem_we for 3 consecutive cycles at addr 0,1,2; load_done=1 the next cycle; host_run -> cpu_run=1 and mem_addr tracks cpu_fetch_addr=5.
- Host gaps: length=4 with host_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addr 0..3; words_loaded=4; DONE reached.
- Bad length: host_start with host_length=0 -> load_error=1. host_length=33 -> load_error=1. host_abort -> IDLE with load_error=0.
- Abort mid-load: abort after 2 of 5 words -> IDLE, words_loaded=0, cpu_run stays 0. A new length=1 session then writes addr 0.
- Full depth: length=32 -> last write at addr 31, words_loaded=32, no write to addr 0 after the first.
- Checksum (macro on): words 0x0001, 0x0002, then 0x0003 -> DONE. Repeat with check word 0x0004 -> ERROR, and no memory write occurs on the check word.
